// File: rtl/arb_mux_n.sv
// N-channel registered mux with fixed-priority or round-robin arbitration.
// Optional packet lock holds the grant until the last beat is accepted.
module arb_mux_n #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 4,
  parameter int MODE   = 1,
  parameter int PKT_EN = 1,
  parameter int CH_W   = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [NUM_CH-1:0]        in_valid,
  input  logic [NUM_CH-1:0]        in_last,
  output logic [NUM_CH-1:0]        in_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [CH_W-1:0]          out_ch,
  output logic                     out_last,
  output logic                     out_valid,
  input  logic                     out_ready
);

  typedef enum logic {ARB, LOCK} state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [CH_W-1:0]   out_ch_q, out_ch_d;
  logic              out_last_q, out_last_d;
  logic              out_valid_q, out_valid_d;
  logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CH_W-1:0]   lock_ch_q, lock_ch_d;

  logic              load_en;
  logic              grant_valid;
  logic [CH_W-1:0]   grant;
  logic              xfer;
  logic              end_grant;

  assign load_en = !out_valid_q | out_ready;
  assign xfer    = load_en & grant_valid;

  // Scan from the highest candidate down so the last hit is the winner.
  always_comb begin
    int idx;
    grant       = '0;
    grant_valid = 1'b0;
    idx         = 0;
    if (state_q == LOCK) begin
      grant       = lock_ch_q;
      grant_valid = in_valid[lock_ch_q];
    end else if (MODE == 0) begin
      for (int i = NUM_CH - 1; i >= 0; i--) begin
        if (in_valid[i]) begin
          grant       = CH_W'(i);
          grant_valid = 1'b1;
        end
      end
    end else begin
      for (int k = NUM_CH - 1; k >= 0; k--) begin
        idx = (int'(rr_ptr_q) + k) % NUM_CH;
        if (in_valid[idx]) begin
          grant       = CH_W'(idx);
          grant_valid = 1'b1;
        end
      end
    end
  end

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      in_ready[i] = xfer & (grant == CH_W'(i));
    end
  end

  assign end_grant = (PKT_EN == 0) | in_last[grant];

  always_comb begin
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q;
    rr_ptr_d    = rr_ptr_q;
    if (xfer) begin
      out_data_d  = in_data[int'(grant)*DATA_W +: DATA_W];
      out_ch_d    = grant;
      out_last_d  = in_last[grant];
      out_valid_d = 1'b1;
      if (end_grant) begin
        rr_ptr_d = (grant == CH_W'(NUM_CH - 1)) ? '0 : grant + 1'b1;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_comb begin
    state_d   = state_q;
    lock_ch_d = lock_ch_q;
    unique case (state_q)
      ARB: begin
        if (xfer && (PKT_EN != 0) && !in_last[grant]) begin
          state_d   = LOCK;
          lock_ch_d = grant;
        end
      end
      LOCK: begin
        if (xfer && in_last[grant]) state_d = ARB;
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ARB;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
      rr_ptr_q    <= '0;
      lock_ch_q   <= '0;
    end else begin
      state_q     <= state_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
      rr_ptr_q    <= rr_ptr_d;
      lock_ch_q   <= lock_ch_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_last  = out_last_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_arb_mux_n.sv
// Directed bench for arb_mux_n: one round-robin and one
// fixed-priority instance driven by the same stimulus.
module tb_arb_mux_n;

  logic        clk;
  logic        rst_n;
  logic [15:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_last;
  logic        out_ready;

  logic [3:0]  rr_ready, fp_ready;
  logic [3:0]  rr_data, fp_data;
  logic [1:0]  rr_ch, fp_ch;
  logic        rr_last, fp_last;
  logic        rr_valid, fp_valid;

  int n_vec;
  int n_err;

  arb_mux_n #(.MODE(1)) u_rr (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(rr_ready),
    .out_data(rr_data), .out_ch(rr_ch),
    .out_last(rr_last), .out_valid(rr_valid),
    .out_ready(out_ready)
  );

  arb_mux_n #(.MODE(0)) u_fp (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(fp_ready),
    .out_data(fp_data), .out_ch(fp_ch),
    .out_last(fp_last), .out_valid(fp_valid),
    .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("watchdog FAIL timeout got running exp finished");
    $fatal(1);
  end

  task automatic chk(input string tag,
                     input logic [15:0] got,
                     input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("%s FAIL got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_ch [5];
    n_vec     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    in_data   = '0;
    in_valid  = '0;
    in_last   = '0;
    out_ready = 1'b0;
    exp_ch    = '{0, 1, 2, 3, 0};
    tick();
    tick();
    chk("rst_valid", 16'(rr_valid), 16'h0);
    chk("rst_data", 16'(rr_data), 16'h0);
    chk("rst_ch", 16'(rr_ch), 16'h0);
    chk("rst_last", 16'(rr_last), 16'h0);
    chk("rst_ready", 16'(rr_ready), 16'h0);
    rst_n = 1'b1;
    tick();

    // single beat from ch2
    in_valid  = 4'b0100;
    in_last   = 4'b0100;
    in_data   = 16'h0A00;
    out_ready = 1'b1;
    #1;
    chk("t2_ready", 16'(rr_ready), 16'h4);
    tick();
    in_valid = '0;
    chk("t2_valid", 16'(rr_valid), 16'h1);
    chk("t2_data", 16'(rr_data), 16'hA);
    chk("t2_ch", 16'(rr_ch), 16'h2);
    chk("t2_last", 16'(rr_last), 16'h1);

    // asynchronous reset with no clock edge
    #3;
    rst_n = 1'b0;
    #1;
    chk("t1_valid", 16'(rr_valid), 16'h0);
    chk("t1_data", 16'(rr_data), 16'h0);
    chk("t1_ch", 16'(rr_ch), 16'h0);
    chk("t1_last", 16'(rr_last), 16'h0);
    #1;
    rst_n = 1'b1;
    tick();

    // all channels valid: rr rotates, fp sticks to ch0
    in_valid = 4'hF;
    in_last  = 4'hF;
    in_data  = 16'h4321;
    #1;
    chk("t3_ready", 16'(rr_ready), 16'h1);
    chk("t4_ready", 16'(fp_ready), 16'h1);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t3_ch", 16'(rr_ch), 16'(exp_ch[k]));
      chk("t3_data", 16'(rr_data), 16'(exp_ch[k] + 1));
      chk("t4_ch", 16'(fp_ch), 16'h0);
      chk("t4_ready", 16'(fp_ready), 16'h1);
    end
    in_valid = '0;
    tick();
    chk("t3_drain", 16'(rr_valid), 16'h0);

    // back-pressure then drain and load in one cycle
    in_valid = 4'b1000;
    in_last  = 4'b1000;
    in_data  = 16'h7000;
    tick();
    chk("t5_ch3", 16'(rr_ch), 16'h3);
    out_ready = 1'b0;
    in_valid  = 4'b0001;
    in_last   = 4'b0001;
    in_data   = 16'h0005;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("t5_ready", 16'(rr_ready), 16'h0);
      tick();
      chk("t5_data", 16'(rr_data), 16'h7);
      chk("t5_ch", 16'(rr_ch), 16'h3);
      chk("t5_valid", 16'(rr_valid), 16'h1);
    end
    out_ready = 1'b1;
    #1;
    chk("t5_reload", 16'(rr_ready), 16'h1);
    tick();
    chk("t5_ndata", 16'(rr_data), 16'h5);
    chk("t5_nch", 16'(rr_ch), 16'h0);
    chk("t5_nvalid", 16'(rr_valid), 16'h1);
    in_valid = '0;
    tick();

    // 3-beat packet on ch1 with a gap, ch0 competing
    in_valid = 4'b0011;
    in_last  = 4'b0001;
    in_data  = 16'h001C;
    #1;
    chk("t6_rdy1", 16'(rr_ready), 16'h2);
    tick();
    chk("t6_ch1", 16'(rr_ch), 16'h1);
    chk("t6_d1", 16'(rr_data), 16'h1);
    in_data = 16'h002C;
    tick();
    chk("t6_ch2", 16'(rr_ch), 16'h1);
    chk("t6_d2", 16'(rr_data), 16'h2);
    in_valid = 4'b0001;
    #1;
    chk("t6_gap_rdy", 16'(rr_ready), 16'h0);
    tick();
    chk("t6_gap_vld", 16'(rr_valid), 16'h0);
    in_valid = 4'b0011;
    in_last  = 4'b0011;
    in_data  = 16'h003C;
    #1;
    chk("t6_rdy3", 16'(rr_ready), 16'h2);
    tick();
    chk("t6_ch3", 16'(rr_ch), 16'h1);
    chk("t6_d3", 16'(rr_data), 16'h3);
    chk("t6_last", 16'(rr_last), 16'h1);
    in_valid = 4'b0001;
    tick();
    chk("t6_ch0", 16'(rr_ch), 16'h0);
    chk("t6_d0", 16'(rr_data), 16'hC);
    in_valid = '0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
